// File: rtl/step_controller_pkg.sv
// Package for the step controller: FSM state encoding and default debounce depth.
// Imported by the interface, the debouncer and the top.
package step_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_STEP = 2'b10,
    S_HALT = 2'b11
  } step_state_t;

  localparam int DEBOUNCE_CYCLES_DEF = 16;

endpackage

// File: rtl/step_controller_if.sv
// Interface bundling the step controller's conditioned-control signals.
//   clk_b      raw step push-button (asynchronous, bouncy)
//   debug      raw mode switch: 1 = single-step, 0 = free run (asynchronous)
//   halt       synchronous halt request from the core
//   cpu_en     registered clock enable to the core
//   step_count saturating count of cycles with cpu_en high
//   mode       current FSM state, for display
// Signal contract: there is no valid/ready pair here. cpu_en is a level
// enable, one bit per clk_c cycle; every cycle it is high the core advances
// exactly once and step_count counts that cycle. halt is sampled every cycle
// and needs no acknowledge.
// master: the side that drives the raw inputs (board / bench).
// slave:  the step controller.
interface step_controller_if #(
  parameter int CNT_W = 32
);
  import step_pkg::*;

  logic             clk_b;
  logic             debug;
  logic             halt;
  logic             cpu_en;
  logic [CNT_W-1:0] step_count;
  step_state_t      mode;

  modport master (
    output clk_b, debug, halt,
    input  cpu_en, step_count, mode
  );

  modport slave (
    input  clk_b, debug, halt,
    output cpu_en, step_count, mode
  );
endinterface

// File: rtl/step_controller_sync_debounce.sv
// 2-FF synchronizer followed by a debouncer.
//   clk_c  system clock
//   reset  asynchronous active-low reset
//   din    raw asynchronous input
//   dout   debounced level; toggles on the edge where the synchronized input
//          has disagreed with dout for DEBOUNCE_CYCLES consecutive cycles
// RESET_VAL sets the level every flop takes in reset. The mode-switch
// instance resets to 1 so the core wakes up in single-step and only starts
// free running once a settled debug=0 has been seen.
module sync_debounce
  import step_pkg::*;
#(
  parameter int   DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter logic RESET_VAL       = 1'b0
) (
  input  logic clk_c,
  input  logic reset,
  input  logic din,
  output logic dout
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync_1;
  logic          sync_2;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk_c or negedge reset) begin
    if (!reset) begin
      sync_1 <= RESET_VAL;
      sync_2 <= RESET_VAL;
      dout   <= RESET_VAL;
      cnt    <= '0;
    end else begin
      sync_1 <= din;
      sync_2 <= sync_1;
      if (sync_2 != dout) begin
        // cnt holds the number of earlier disagreeing cycles in this run
        if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
          dout <= ~dout;
          cnt  <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end
endmodule

// File: rtl/step_controller.sv
// Execution-control front end: turns the step button and debug switch into
// one registered clock enable (cpu_en) for the core.
//   clk_c  system clock, all flops on its rising edge
//   reset  asynchronous active-low reset
//   bus    step_controller_if.slave: clk_b, debug, halt in;
//          cpu_en, step_count, mode out
// Run mode: cpu_en every cycle. Debug mode: one cpu_en cycle per clean press.
// halt wins over a mode change, which wins over a step press. S_HALT is left
// only through reset.
module step_controller
  import step_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int CNT_W           = 32
) (
  input  logic                clk_c,
  input  logic                reset,
  step_controller_if.slave    bus
);
  logic             db_btn;
  logic             db_btn_q;
  logic             db_debug;
  logic             step_pulse;
  step_state_t      state;
  step_state_t      next_state;
  logic             cpu_en;
  logic [CNT_W-1:0] step_count;

  sync_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .RESET_VAL(1'b0)) u_btn (
    .clk_c (clk_c),
    .reset (reset),
    .din   (bus.clk_b),
    .dout  (db_btn)
  );

  sync_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .RESET_VAL(1'b1)) u_dbg (
    .clk_c (clk_c),
    .reset (reset),
    .din   (bus.debug),
    .dout  (db_debug)
  );

  // Rising debounced edge only; release produces nothing.
  assign step_pulse = db_btn & ~db_btn_q;

  always_comb begin
    next_state = state;
    unique case (state)
      S_IDLE: begin
        if (bus.halt)       next_state = S_HALT;
        else if (!db_debug) next_state = S_RUN;
        else if (step_pulse) next_state = S_STEP;
      end
      S_RUN: begin
        if (bus.halt)       next_state = S_HALT;
        else if (db_debug)  next_state = S_IDLE;
      end
      S_STEP: begin
        // Exactly one cycle; a pulse seen here is dropped.
        if (bus.halt)       next_state = S_HALT;
        else if (!db_debug) next_state = S_RUN;
        else                next_state = S_IDLE;
      end
      S_HALT: next_state = S_HALT;
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_c or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      cpu_en   <= 1'b0;
      db_btn_q <= 1'b0;
    end else begin
      state    <= next_state;
      cpu_en   <= (next_state == S_RUN) || (next_state == S_STEP);
      db_btn_q <= db_btn;
    end
  end

  // Saturating: holds at all-ones.
  always_ff @(posedge clk_c or negedge reset) begin
    if (!reset) begin
      step_count <= '0;
    end else if (cpu_en && (step_count != '1)) begin
      step_count <= step_count + CNT_W'(1);
    end
  end

  assign bus.cpu_en     = cpu_en;
  assign bus.step_count = step_count;
  assign bus.mode       = state;
endmodule
